tri_hit_scheduler: RTL and testbench
====================================

Name: tri_hit_scheduler

Overview:
- Sequences point-in-triangle tests for one query point against a small bank of configurable triangles.
- Time-multiplexes a single shared edge-sign datapath: one edge per cycle, three edges per triangle.
- Returns a hit mask and the lowest hit index over a valid/ready result handshake.
- Sits between the point source (pixel/cursor generator) and downstream logic that consumes per-triangle coverage.

Parameters:
- NTRI, 4, number of triangle slots (2..16).
- IDXW, $clog2(NTRI), width of triangle index fields.
- CW, 12, coordinate width; two's-complement signed.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- cfg_we  in  1  write one vertex when cfg_ready=1.
- cfg_idx  in  IDXW  triangle slot being written.
- cfg_vtx  in  2  vertex number 0..2; value 3 means write is ignored.
- cfg_x, cfg_y  in  CW each  vertex coordinates.
- cfg_clr  in  1  clear all slot-valid bits; honoured only when cfg_ready=1.
- cfg_ready  out  1  high in IDLE and DONE only.
- pt_valid  in  1  query point offered.
- pt_x, pt_y  in  CW each  query point.
- pt_ready  out  1  high in IDLE only.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_mask  out  NTRI  bit i=1 when the point is inside slot i.
- res_hit  out  1  res_mask nonzero.
- res_first  out  IDXW  lowest set bit of res_mask; 0 when res_hit=0.

Behaviour:
- Reset (async, immediate): state IDLE; all vertex registers, slot-valid bits, res_mask, res_first and res_hit are 0; res_valid=0; pt_ready=1; cfg_ready=1.
- Config write: on a clk edge with cfg_we & cfg_ready, vertex cfg_vtx of slot cfg_idx is written.
  - Writing vertex 2 also sets that slot's valid bit.
  - cfg_clr takes priority over cfg_we in the same cycle.
  - Writes are dropped with no effect while cfg_ready=0.
- FSM IDLE -> SCAN -> DONE -> IDLE.
  - IDLE: on pt_valid & pt_ready, capture the point, set idx=0, edge=0, clear the mask accumulator, go to SCAN.
  - SCAN, slot idx invalid: one cycle; mask bit stays 0; advance idx.
  - SCAN, slot idx valid: three cycles, one per edge: edge 0 = (V0,V1), edge 1 = (V1,V2), edge 2 = (V2,V0). Register each edge sign; after edge 2 set mask[idx] = (s0==s1==s2); advance idx.
  - After the last slot (idx = NTRI-1 finished) go to DONE. No wrap-around of idx.
  - DONE: res_valid=1. res_mask, res_first and res_hit are registered and stable until the handshake. On res_valid & res_ready go to IDLE.
- Latency: SCAN takes 3 cycles per valid slot plus 1 per invalid slot. res_valid rises on the edge after the final SCAN cycle.
- Edge-sign arithmetic, for edge (A,B):
  - Sign-extend all operands to CW+1 before subtracting.
  - cross = (P.x-B.x)*(A.y-B.y) - (A.x-B.x)*(P.y-B.y).
  - Products are 2*(CW+1) bits; cross is 2*CW+3 bits. No truncation at any coordinate values.
  - sign = (cross >= 0).
  - Boundary points (cross=0) count as non-negative. A degenerate (collinear) slot therefore reports inside for points on its line.
- Config or point changes during SCAN do not affect the scan in progress; the point is held in a captured register.
- Reset asserted mid-SCAN or in DONE: immediate return to IDLE; the result is discarded; config is cleared.

Decomposition:
- Shared package tri_pkg holds:
  - the CW default;
  - the FSM state enum (IDLE, SCAN, DONE);
  - the edge-order constants (vertex pairs 0-1, 1-2, 2-0);
  - the derived widths CW+1 and 2*CW+3.
- One sub-module, edge_sign: purely combinational, inputs P, A, B, output sign. Instantiated once; the scheduler muxes vertices into it by edge counter.

Test Plan:
- Slot0 = (-6,-1),(3,3),(3,-3); slot1 = (20,-2),(-1,8),(20,12); query (0,0) -> res_mask=0001, res_hit=1, res_first=0; res_valid 9 cycles after accept (NTRI=4: 2 valid x3 + 2 invalid x1 + 1).
- Same config, query (10,5) -> res_mask=0010, res_first=1. Query (-3,3) -> res_mask=0000, res_hit=0, res_first=0.
- Slot2 = (-2048,-2048),(2047,-2048),(-2048,2047); query (-2000,-2000) -> mask bit2=1. Checks there is no overflow at full range.
- Hold res_ready=0 for 5 cycles in DONE -> res_* stable, pt_ready=0. Meanwhile cfg_we to slot0 is accepted (cfg_ready=1) and pt_valid is ignored. After res_ready, the next query sees the new slot0.
- cfg_we during SCAN -> dropped; result matches the old config. cfg_clr and cfg_we in the same cycle -> all slots invalid; the next query returns mask 0 after 4 SCAN cycles.
- Assert rst in the 2nd SCAN cycle -> res_valid never rises, outputs 0 immediately, pt_ready=1, all slots invalid.

Source files
------------

// File: rtl/tri_pkg.sv
// Shared types, widths and edge ordering for the triangle hit scheduler.
package tri_pkg;

  localparam int CW_DEF      = 12;
  localparam int EXT_W_DEF   = CW_DEF + 1;
  localparam int CROSS_W_DEF = 2 * CW_DEF + 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [1:0] EDGE0_A  = 2'd0;
  localparam logic [1:0] EDGE0_B  = 2'd1;
  localparam logic [1:0] EDGE1_A  = 2'd1;
  localparam logic [1:0] EDGE1_B  = 2'd2;
  localparam logic [1:0] EDGE2_A  = 2'd2;
  localparam logic [1:0] EDGE2_B  = 2'd0;
  localparam logic [1:0] VTX_NONE = 2'd3;

  function automatic int ext_w(input int cw);
    return cw + 1;
  endfunction

  function automatic int cross_w(input int cw);
    return 2 * cw + 3;
  endfunction

  function automatic logic [1:0] edge_vtx_a(input logic [1:0] e);
    case (e)
      2'd0:    return EDGE0_A;
      2'd1:    return EDGE1_A;
      2'd2:    return EDGE2_A;
      default: return EDGE0_A;
    endcase
  endfunction

  function automatic logic [1:0] edge_vtx_b(input logic [1:0] e);
    case (e)
      2'd0:    return EDGE0_B;
      2'd1:    return EDGE1_B;
      2'd2:    return EDGE2_B;
      default: return EDGE0_B;
    endcase
  endfunction

endpackage

// File: rtl/tri_hit_scheduler_edge_sign.sv
// Combinational edge-function sign for point P against directed edge (A,B).
module edge_sign
  import tri_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic [CW-1:0] i_p_x,
  input  logic [CW-1:0] i_p_y,
  input  logic [CW-1:0] i_a_x,
  input  logic [CW-1:0] i_a_y,
  input  logic [CW-1:0] i_b_x,
  input  logic [CW-1:0] i_b_y,
  output logic          o_sign
);

  localparam int EW = ext_w(CW);
  localparam int PW = 2 * EW;
  localparam int XW = cross_w(CW);

  logic signed [EW-1:0] w_dx_pb, w_dy_ab, w_dx_ab, w_dy_pb;
  logic signed [PW-1:0] w_m1, w_m2;
  logic signed [XW-1:0] w_cross;

  // Differences are taken one bit wider so full-range coordinates never wrap.
  assign w_dx_pb = $signed({i_p_x[CW-1], i_p_x}) - $signed({i_b_x[CW-1], i_b_x});
  assign w_dy_ab = $signed({i_a_y[CW-1], i_a_y}) - $signed({i_b_y[CW-1], i_b_y});
  assign w_dx_ab = $signed({i_a_x[CW-1], i_a_x}) - $signed({i_b_x[CW-1], i_b_x});
  assign w_dy_pb = $signed({i_p_y[CW-1], i_p_y}) - $signed({i_b_y[CW-1], i_b_y});

  assign w_m1    = PW'(w_dx_pb) * PW'(w_dy_ab);
  assign w_m2    = PW'(w_dx_ab) * PW'(w_dy_pb);
  assign w_cross = XW'(w_m1) - XW'(w_m2);
  assign o_sign  = ~w_cross[XW-1];

endmodule

// File: rtl/tri_hit_scheduler.sv
// Scans one query point against NTRI triangle slots through a single shared
// edge-sign unit and returns the coverage mask over a valid/ready handshake.
module tri_hit_scheduler
  import tri_pkg::*;
#(
  parameter int NTRI = 4,
  parameter int IDXW = $clog2(NTRI),
  parameter int CW   = CW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cfg_we,
  input  logic [IDXW-1:0] cfg_idx,
  input  logic [1:0]      cfg_vtx,
  input  logic [CW-1:0]   cfg_x,
  input  logic [CW-1:0]   cfg_y,
  input  logic            cfg_clr,
  output logic            cfg_ready,
  input  logic            pt_valid,
  input  logic [CW-1:0]   pt_x,
  input  logic [CW-1:0]   pt_y,
  output logic            pt_ready,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [NTRI-1:0] res_mask,
  output logic            res_hit,
  output logic [IDXW-1:0] res_first
);

  logic [CW-1:0]   r_vx [NTRI][3];
  logic [CW-1:0]   r_vy [NTRI][3];
  logic [NTRI-1:0] r_slot_vld;

  state_t          r_state;
  logic [CW-1:0]   r_px, r_py;
  logic [IDXW-1:0] r_idx;
  logic [1:0]      r_edge;
  logic            r_s0, r_s1;
  logic [NTRI-1:0] r_acc;
  logic [NTRI-1:0] r_mask;
  logic [IDXW-1:0] r_first;
  logic            r_hit, r_res_valid, r_pt_ready, r_cfg_ready;

  logic [1:0]      w_a_sel, w_b_sel;
  logic [CW-1:0]   w_ax, w_ay, w_bx, w_by;
  logic            w_sign, w_bit, w_step_done, w_last;
  logic [NTRI-1:0] w_mask_next;
  logic [IDXW-1:0] w_first;

  assign w_a_sel = edge_vtx_a(r_edge);
  assign w_b_sel = edge_vtx_b(r_edge);
  assign w_ax    = r_vx[r_idx][w_a_sel];
  assign w_ay    = r_vy[r_idx][w_a_sel];
  assign w_bx    = r_vx[r_idx][w_b_sel];
  assign w_by    = r_vy[r_idx][w_b_sel];

  edge_sign #(.CW(CW)) u_edge_sign (
    .i_p_x (r_px),
    .i_p_y (r_py),
    .i_a_x (w_ax),
    .i_a_y (w_ay),
    .i_b_x (w_bx),
    .i_b_y (w_by),
    .o_sign(w_sign)
  );

  // An invalid slot finishes in one cycle; a valid one on its third edge.
  assign w_step_done = !r_slot_vld[r_idx] || (r_edge == 2'd2);
  assign w_bit       = r_slot_vld[r_idx] && (r_edge == 2'd2) &&
                       (r_s0 == r_s1) && (r_s1 == w_sign);
  assign w_last      = (r_idx == IDXW'(NTRI - 1));

  // Mask including the slot finishing this cycle, and its lowest set bit.
  always_comb begin
    w_mask_next        = r_acc;
    w_mask_next[r_idx] = w_bit;
    w_first            = '0;
    for (int i = NTRI - 1; i >= 0; i--) begin
      w_first = w_mask_next[i] ? IDXW'(i) : w_first;
    end
  end

  // Vertex bank and slot-valid bits; writes only land while cfg_ready is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot_vld <= '0;
      for (int i = 0; i < NTRI; i++) begin
        for (int v = 0; v < 3; v++) begin
          r_vx[i][v] <= '0;
          r_vy[i][v] <= '0;
        end
      end
    end else if (r_cfg_ready) begin
      if (cfg_clr) begin
        r_slot_vld <= '0;
      end else if (cfg_we && (cfg_vtx != VTX_NONE)) begin
        r_vx[cfg_idx][cfg_vtx] <= cfg_x;
        r_vy[cfg_idx][cfg_vtx] <= cfg_y;
        if (cfg_vtx == 2'd2) begin
          r_slot_vld[cfg_idx] <= 1'b1;
        end
      end
    end
  end

  // Scan sequencer with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_px        <= '0;
      r_py        <= '0;
      r_idx       <= '0;
      r_edge      <= 2'd0;
      r_s0        <= 1'b0;
      r_s1        <= 1'b0;
      r_acc       <= '0;
      r_mask      <= '0;
      r_first     <= '0;
      r_hit       <= 1'b0;
      r_res_valid <= 1'b0;
      r_pt_ready  <= 1'b1;
      r_cfg_ready <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (pt_valid && r_pt_ready) begin
            r_px        <= pt_x;
            r_py        <= pt_y;
            r_idx       <= '0;
            r_edge      <= 2'd0;
            r_acc       <= '0;
            r_pt_ready  <= 1'b0;
            r_cfg_ready <= 1'b0;
            r_state     <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          case (r_edge)
            2'd0:    r_s0 <= w_sign;
            2'd1:    r_s1 <= w_sign;
            default: ;
          endcase
          if (w_step_done) begin
            r_edge <= 2'd0;
            r_acc  <= w_mask_next;
            if (w_last) begin
              r_mask      <= w_mask_next;
              r_hit       <= |w_mask_next;
              r_first     <= w_first;
              r_res_valid <= 1'b1;
              r_cfg_ready <= 1'b1;
              r_state     <= ST_DONE;
            end else begin
              r_idx <= r_idx + 1'b1;
            end
          end else begin
            r_edge <= r_edge + 2'd1;
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_pt_ready  <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_res_valid <= 1'b0;
          r_pt_ready  <= 1'b1;
          r_cfg_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign cfg_ready = r_cfg_ready;
  assign pt_ready  = r_pt_ready;
  assign res_valid = r_res_valid;
  assign res_mask  = r_mask;
  assign res_hit   = r_hit;
  assign res_first = r_first;

endmodule

// File: tb/tb_tri_hit_scheduler.sv
// Self-checking bench: directed scenarios plus randomized configs and queries
// compared against a plain-arithmetic point-in-triangle model.
module tb_tri_hit_scheduler;

  localparam int NTRI = 4;
  localparam int IDXW = 2;
  localparam int CW   = 12;

  logic            clk = 1'b0;
  logic            rst;
  logic            cfg_we, cfg_clr;
  logic [IDXW-1:0] cfg_idx;
  logic [1:0]      cfg_vtx;
  logic [CW-1:0]   cfg_x, cfg_y;
  logic            cfg_ready;
  logic            pt_valid;
  logic [CW-1:0]   pt_x, pt_y;
  logic            pt_ready, res_valid, res_ready;
  logic [NTRI-1:0] res_mask;
  logic            res_hit;
  logic [IDXW-1:0] res_first;

  int checks   = 0;
  int failures = 0;

  int              m_x [NTRI][3];
  int              m_y [NTRI][3];
  bit              m_vld [NTRI];
  logic [NTRI-1:0] exp_mask;
  int              exp_lat;
  int              lat_cnt;

  tri_hit_scheduler #(.NTRI(NTRI), .IDXW(IDXW), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_vtx(cfg_vtx),
    .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_clr(cfg_clr), .cfg_ready(cfg_ready),
    .pt_valid(pt_valid), .pt_x(pt_x), .pt_y(pt_y), .pt_ready(pt_ready),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_mask(res_mask), .res_hit(res_hit), .res_first(res_first)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Point is inside when all three edge functions share a sign (zero counts as non-negative).
  function automatic bit inside_tri(input int s, input int px, input int py);
    bit     sg [3];
    int     b;
    longint c;
    for (int a = 0; a < 3; a++) begin
      b = (a + 1) % 3;
      c = longint'(px - m_x[s][b]) * longint'(m_y[s][a] - m_y[s][b])
        - longint'(m_x[s][a] - m_x[s][b]) * longint'(py - m_y[s][b]);
      sg[a] = (c >= 0);
    end
    return (sg[0] == sg[1]) && (sg[1] == sg[2]);
  endfunction

  task automatic predict(input int px, input int py);
    exp_mask = '0;
    exp_lat  = 1;
    for (int s = 0; s < NTRI; s++) begin
      if (m_vld[s]) begin
        exp_lat    += 3;
        exp_mask[s] = inside_tri(s, px, py);
      end else begin
        exp_lat += 1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    lat_cnt++;
  endtask

  task automatic do_cfg(input int idx, input int vtx, input int x, input int y);
    cfg_we  = 1'b1;
    cfg_idx = IDXW'(idx);
    cfg_vtx = 2'(vtx);
    cfg_x   = CW'(x);
    cfg_y   = CW'(y);
    tick();
    cfg_we = 1'b0;
    if (vtx != 3) begin
      m_x[idx][vtx] = x;
      m_y[idx][vtx] = y;
      if (vtx == 2) m_vld[idx] = 1'b1;
    end
  endtask

  task automatic launch(input int px, input int py);
    predict(px, py);
    pt_valid = 1'b1;
    pt_x     = CW'(px);
    pt_y     = CW'(py);
    lat_cnt  = 0;
    tick();
    pt_valid = 1'b0;
    check_eq("pt_ready_scan", 32'(pt_ready), 32'd0);
  endtask

  task automatic wait_result(input string tag);
    int f;
    f = 0;
    for (int i = NTRI - 1; i >= 0; i--) if (exp_mask[i]) f = i;
    while (!res_valid && lat_cnt < 200) tick();
    check_eq({tag, "_lat"},   32'(lat_cnt),   32'(exp_lat));
    check_eq({tag, "_mask"},  32'(res_mask),  32'(exp_mask));
    check_eq({tag, "_hit"},   32'(res_hit),   32'(|exp_mask));
    check_eq({tag, "_first"}, 32'(res_first), 32'(f));
  endtask

  task automatic accept_result();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check_eq("rv_cleared", 32'(res_valid), 32'd0);
    check_eq("pt_ready_idle", 32'(pt_ready), 32'd1);
  endtask

  task automatic do_query(input string tag, input int px, input int py);
    launch(px, py);
    wait_result(tag);
    accept_result();
  endtask

  task automatic load_slot01();
    do_cfg(0, 0, -6, -1); do_cfg(0, 1, 3, 3);  do_cfg(0, 2, 3, -3);
    do_cfg(1, 0, 20, -2); do_cfg(1, 1, -1, 8); do_cfg(1, 2, 20, 12);
  endtask

  initial begin
    bit seen;
    rst = 1'b1; cfg_we = 1'b0; cfg_clr = 1'b0; cfg_idx = '0; cfg_vtx = 2'd0;
    cfg_x = '0; cfg_y = '0; pt_valid = 1'b0; pt_x = '0; pt_y = '0; res_ready = 1'b0;
    #1;
    check_eq("rst_res_valid", 32'(res_valid), 32'd0);
    check_eq("rst_pt_ready",  32'(pt_ready),  32'd1);
    check_eq("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    check_eq("rst_mask",      32'(res_mask),  32'd0);
    check_eq("rst_hit",       32'(res_hit),   32'd0);
    check_eq("rst_first",     32'(res_first), 32'd0);
    tick(); tick();
    rst = 1'b0;

    load_slot01();
    launch(0, 0);   wait_result("q00");  check_eq("q00_const", 32'(res_mask), 32'h1); accept_result();
    launch(10, 5);  wait_result("q105"); check_eq("q105_first", 32'(res_first), 32'd1);
    check_eq("q105_const", 32'(res_mask), 32'h2); accept_result();
    launch(-3, 3);  wait_result("qm33"); check_eq("qm33_const", 32'(res_mask), 32'h0); accept_result();

    do_cfg(2, 0, -2048, -2048); do_cfg(2, 1, 2047, -2048); do_cfg(2, 2, -2048, 2047);
    launch(-2000, -2000); wait_result("full"); check_eq("full_bit2", 32'(res_mask[2]), 32'd1);
    accept_result();

    // Result held while consumer stalls; config writes land, points are refused.
    launch(0, 0); wait_result("hold");
    for (int k = 0; k < 5; k++) begin
      pt_valid = 1'b1;
      pt_x     = CW'(5);
      if (k == 0)      do_cfg(0, 0, 10, 0);
      else if (k == 1) do_cfg(0, 1, 11, 0);
      else if (k == 2) do_cfg(0, 2, 10, 1);
      else             tick();
      check_eq("hold_rv",   32'(res_valid), 32'd1);
      check_eq("hold_mask", 32'(res_mask),  32'(exp_mask));
      check_eq("hold_ptr",  32'(pt_ready),  32'd0);
      check_eq("hold_cfgr", 32'(cfg_ready), 32'd1);
    end
    pt_valid = 1'b0;
    accept_result();
    launch(0, 0); wait_result("newslot0"); check_eq("newslot0_b0", 32'(res_mask[0]), 32'd0);
    accept_result();

    // Config traffic during a scan must be dropped.
    launch(10, 5);
    check_eq("scan_cfgr", 32'(cfg_ready), 32'd0);
    cfg_we = 1'b1; cfg_idx = 2'd1; cfg_vtx = 2'd0; cfg_x = CW'(-100); cfg_y = CW'(-100);
    tick();
    cfg_we = 1'b0; cfg_clr = 1'b1;
    tick();
    cfg_clr = 1'b0;
    wait_result("drop");
    accept_result();
    launch(10, 5); wait_result("drop_after"); accept_result();

    cfg_clr = 1'b1; cfg_we = 1'b1; cfg_idx = 2'd3; cfg_vtx = 2'd2; cfg_x = '0; cfg_y = '0;
    tick();
    cfg_clr = 1'b0; cfg_we = 1'b0;
    for (int s = 0; s < NTRI; s++) m_vld[s] = 1'b0;
    do_query("clr", 1, 1);

    // Reset in the middle of a scan throws the result away and wipes config.
    load_slot01();
    do_query("pre_rst", 0, 0);
    launch(0, 0);
    tick();
    rst = 1'b1;
    #1;
    check_eq("mrst_rv",   32'(res_valid), 32'd0);
    check_eq("mrst_ptr",  32'(pt_ready),  32'd1);
    check_eq("mrst_cfgr", 32'(cfg_ready), 32'd1);
    check_eq("mrst_mask", 32'(res_mask),  32'd0);
    check_eq("mrst_hit",  32'(res_hit),   32'd0);
    tick();
    rst = 1'b0;
    for (int s = 0; s < NTRI; s++) begin
      m_vld[s] = 1'b0;
      for (int v = 0; v < 3; v++) begin m_x[s][v] = 0; m_y[s][v] = 0; end
    end
    seen = 1'b0;
    for (int k = 0; k < 15; k++) begin tick(); if (res_valid) seen = 1'b1; end
    check_eq("mrst_no_rv", 32'(seen), 32'd0);
    do_query("post_rst", 0, 0);

    // Random configs and queries against the model.
    for (int it = 0; it < 40; it++) begin
      int nw, wide, hold;
      nw   = $urandom_range(0, 5);
      wide = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 9) == 0) begin
        cfg_clr = 1'b1; tick(); cfg_clr = 1'b0;
        for (int s = 0; s < NTRI; s++) m_vld[s] = 1'b0;
      end
      for (int w = 0; w < nw; w++) begin
        if (wide) do_cfg($urandom_range(0, NTRI - 1), $urandom_range(0, 3),
                         $urandom_range(0, 4095) - 2048, $urandom_range(0, 4095) - 2048);
        else      do_cfg($urandom_range(0, NTRI - 1), $urandom_range(0, 3),
                         $urandom_range(0, 127) - 64, $urandom_range(0, 127) - 64);
      end
      if (wide) launch($urandom_range(0, 4095) - 2048, $urandom_range(0, 4095) - 2048);
      else      launch($urandom_range(0, 127) - 64, $urandom_range(0, 127) - 64);
      wait_result("rnd");
      hold = $urandom_range(0, 3);
      for (int h = 0; h < hold; h++) tick();
      check_eq("rnd_hold_mask", 32'(res_mask), 32'(exp_mask));
      accept_result();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
